// File: rtl/dma_ahb_pkg.sv
// rtl/dma_ahb_pkg.sv - shared types and constants for the DMA AHB channel scheduler
package dma_ahb_pkg;

  localparam int ADDR_W  = 32;
  localparam int BNUM_W  = 16;
  localparam int BURST_W = 5;

  localparam logic [BURST_W-1:0] BURST_SINGLE = 5'd1;
  localparam logic [BURST_W-1:0] BURST_INC4   = 5'd4;
  localparam logic [BURST_W-1:0] BURST_INC8   = 5'd8;
  localparam logic [BURST_W-1:0] BURST_INC16  = 5'd16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK  = 3'd1,
    ST_GO   = 3'd2,
    ST_RUN  = 3'd3,
    ST_REL  = 3'd4
  } sched_state_e;

  // A zero-length or zero-burst descriptor is silently ignored by the master,
  // so it must be bounced here or the scheduler would wait forever.
  function automatic logic desc_reject(input logic [BNUM_W-1:0]  bnum,
                                       input logic [BURST_W-1:0] burst);
    return (bnum == '0) || (burst == '0);
  endfunction

endpackage

// File: rtl/dma_ahb_rr_arb.sv
// rtl/dma_ahb_rr_arb.sv - round-robin arbiter with last-grant pointer
module dma_ahb_rr_arb #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  input  logic [NCH-1:0] req_i,
  input  logic           advance_i,
  output logic [NCH-1:0] gnt_o,
  output logic [CHW-1:0] gnt_idx_o,
  output logic [CHW-1:0] last_o
);

  logic [CHW-1:0] last_q;
  logic [CHW-1:0] last_d;

  // Search upward from the channel after the last winner, wrapping past NCH-1.
  always_comb begin
    int             c;
    logic [CHW-1:0] ci;
    logic           found;
    c         = 0;
    ci        = '0;
    found     = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int k = 1; k <= NCH; k++) begin
      c = int'(last_q) + k;
      if (c >= NCH) c = c - NCH;
      ci = CHW'(c);
      if (!found && req_i[ci]) begin
        found     = 1'b1;
        gnt_o[ci] = 1'b1;
        gnt_idx_o = ci;
      end
    end
  end

  // The pointer only moves when the owner actually takes the grant.
  always_comb begin
    last_d = last_q;
    if (advance_i) last_d = gnt_idx_o;
  end

  // Pointer register; resets so that channel 0 wins the first arbitration.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) last_q <= CHW'(NCH - 1);
    else          last_q <= last_d;
  end

  assign last_o = last_q;

endmodule

// File: rtl/dma_ahb_chan_sched.sv
// rtl/dma_ahb_chan_sched.sv - multi-channel scheduler in front of a single-channel DMA AHB master
module dma_ahb_chan_sched
  import dma_ahb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic                   HRESETn,
  input  logic                   HCLK,
  input  logic                   EN,
  input  logic [NCH-1:0]         req_vld,
  output logic [NCH-1:0]         req_rdy,
  input  logic [NCH*ADDR_W-1:0]  req_src,
  input  logic [NCH*ADDR_W-1:0]  req_dst,
  input  logic [NCH*BNUM_W-1:0]  req_bnum,
  input  logic [NCH*BURST_W-1:0] req_burst,
  output logic [NCH-1:0]         cmp_vld,
  output logic                   cmp_err,
  output logic                   sched_busy,
  output logic [CHW-1:0]         cur_chan,
  output logic                   DMA_EN,
  output logic                   DMA_GO,
  output logic [ADDR_W-1:0]      DMA_SRC,
  output logic [ADDR_W-1:0]      DMA_DST,
  output logic [BNUM_W-1:0]      DMA_BNUM,
  output logic [BURST_W-1:0]     DMA_BURST,
  input  logic                   DMA_BUSY,
  input  logic                   DMA_DONE
);

  sched_state_e         state_q;
  logic                 en_q;
  logic                 go_q;
  logic                 busy_q;
  logic [NCH-1:0]       cmp_vld_q;
  logic                 cmp_err_q;
  logic [ADDR_W-1:0]    src_q;
  logic [ADDR_W-1:0]    dst_q;
  logic [BNUM_W-1:0]    bnum_q;
  logic [BURST_W-1:0]   burst_q;

  logic [NCH-1:0]       arb_req;
  logic [NCH-1:0]       arb_gnt;
  logic [CHW-1:0]       arb_idx;
  logic [CHW-1:0]       last_grant;
  logic                 arb_open;
  logic                 grant;
  logic [NCH-1:0]       cur_onehot;

  logic [ADDR_W-1:0]    sel_src;
  logic [ADDR_W-1:0]    sel_dst;
  logic [BNUM_W-1:0]    sel_bnum;
  logic [BURST_W-1:0]   sel_burst;

  // A channel whose completion is pulsing this cycle is kept out of arbitration,
  // so req_rdy and cmp_vld never coincide on the same channel.
  assign arb_req  = req_vld & ~cmp_vld_q;

  // Grants only while idle, enabled on both sides of the DMA_EN register, and
  // with the master back in its ready state.
  assign arb_open = (state_q == ST_IDLE) && EN && en_q && !DMA_DONE;
  assign grant    = arb_open && (arb_gnt != '0);
  assign req_rdy  = arb_open ? arb_gnt : '0;

  dma_ahb_rr_arb #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_i     (arb_req),
    .advance_i (grant),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .last_o    (last_grant)
  );

  // The pointer is updated on every grant, so it always names the channel in flight.
  assign cur_onehot = NCH'(1) << last_grant;
  assign cur_chan   = busy_q ? last_grant : '0;

  // Pick the winning channel's descriptor fields out of the flattened buses.
  always_comb begin
    sel_src   = '0;
    sel_dst   = '0;
    sel_bnum  = '0;
    sel_burst = '0;
    for (int i = 0; i < NCH; i++) begin
      if (arb_idx == CHW'(i)) begin
        sel_src   = req_src[i*ADDR_W +: ADDR_W];
        sel_dst   = req_dst[i*ADDR_W +: ADDR_W];
        sel_bnum  = req_bnum[i*BNUM_W +: BNUM_W];
        sel_burst = req_burst[i*BURST_W +: BURST_W];
      end
    end
  end

  // Scheduler FSM with registered GO/EN/busy/completion outputs and descriptor latch.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      cmp_vld_q <= '0;
      cmp_err_q <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      bnum_q    <= '0;
      burst_q   <= '0;
    end else begin
      en_q      <= EN;
      cmp_vld_q <= '0;
      cmp_err_q <= 1'b0;
      if (!EN) begin
        // Dropping EN also resets the master through DMA_EN; whatever was in
        // flight is reported as aborted.
        go_q    <= 1'b0;
        state_q <= ST_IDLE;
        if (busy_q) begin
          cmp_vld_q <= cur_onehot;
          cmp_err_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (grant) begin
              src_q   <= sel_src;
              dst_q   <= sel_dst;
              bnum_q  <= sel_bnum;
              burst_q <= sel_burst;
              busy_q  <= 1'b1;
              state_q <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (desc_reject(bnum_q, burst_q)) begin
              cmp_vld_q <= cur_onehot;
              cmp_err_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              go_q    <= 1'b1;
              state_q <= ST_GO;
            end
          end
          ST_GO: begin
            // A very short transfer may finish before BUSY is ever seen.
            if (DMA_BUSY || DMA_DONE) state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (DMA_DONE) begin
              go_q    <= 1'b0;
              state_q <= ST_REL;
            end
          end
          ST_REL: begin
            // Completion is only reported once the master is ready again.
            if (!DMA_DONE) begin
              cmp_vld_q <= cur_onehot;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmp_vld    = cmp_vld_q;
  assign cmp_err    = cmp_err_q;
  assign sched_busy = busy_q;
  assign DMA_EN     = en_q;
  assign DMA_GO     = go_q;
  assign DMA_SRC    = src_q;
  assign DMA_DST    = dst_q;
  assign DMA_BNUM   = bnum_q;
  assign DMA_BURST  = burst_q;

endmodule

// File: tb/tb_dma_ahb_chan_sched.sv
// tb/tb_dma_ahb_chan_sched.sv - self-checking bench for dma_ahb_chan_sched
module tb_dma_ahb_chan_sched;
  import dma_ahb_pkg::*;

  localparam int NCH = 4;
  localparam int CHW = 2;

  logic                   HRESETn, HCLK, EN;
  logic [NCH-1:0]         req_vld, req_rdy, cmp_vld;
  logic [NCH*32-1:0]      req_src, req_dst;
  logic [NCH*16-1:0]      req_bnum;
  logic [NCH*5-1:0]       req_burst;
  logic                   cmp_err, sched_busy;
  logic [CHW-1:0]         cur_chan;
  logic                   DMA_EN, DMA_GO;
  logic [31:0]            DMA_SRC, DMA_DST;
  logic [15:0]            DMA_BNUM;
  logic [4:0]             DMA_BURST;
  logic                   DMA_BUSY, DMA_DONE;

  dma_ahb_chan_sched #(.NCH(NCH), .CHW(CHW)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .EN(EN),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_src(req_src), .req_dst(req_dst), .req_bnum(req_bnum), .req_burst(req_burst),
    .cmp_vld(cmp_vld), .cmp_err(cmp_err), .sched_busy(sched_busy), .cur_chan(cur_chan),
    .DMA_EN(DMA_EN), .DMA_GO(DMA_GO), .DMA_SRC(DMA_SRC), .DMA_DST(DMA_DST),
    .DMA_BNUM(DMA_BNUM), .DMA_BURST(DMA_BURST), .DMA_BUSY(DMA_BUSY), .DMA_DONE(DMA_DONE)
  );

  int total, bad;
  int cyc, go_cnt;
  int grant_q[$], grant_cyc_q[$];
  int cmp_ch_q[$], cmp_err_q[$], cmp_cyc_q[$];
  logic [NCH-1:0] gnt_pending, req_post, req_kill;
  int run_len, hold_len, m_st, m_cnt;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [NCH-1:0] m);
    for (int i = 0; i < NCH; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int gq(input int i);
    return (grant_q.size() > i) ? grant_q[i] : -1;
  endfunction
  function automatic int gcq(input int i);
    return (grant_cyc_q.size() > i) ? grant_cyc_q[i] : -1;
  endfunction
  function automatic int cq(input int i);
    return (cmp_ch_q.size() > i) ? cmp_ch_q[i] : -1;
  endfunction
  function automatic int ceq(input int i);
    return (cmp_err_q.size() > i) ? cmp_err_q[i] : -1;
  endfunction
  function automatic int ccq(input int i);
    return (cmp_cyc_q.size() > i) ? cmp_cyc_q[i] : -1;
  endfunction

  // Environment: requesters drop req_vld after the granting edge, master model
  // runs just after each rising edge, monitor samples on the falling edge.
  initial begin
    req_vld = '0; DMA_BUSY = 1'b0; DMA_DONE = 1'b0;
    m_st = 0; m_cnt = 0; gnt_pending = '0; cyc = 0; go_cnt = 0;
    forever begin
      @(posedge HCLK); #1;
      req_vld = (req_vld & ~gnt_pending & ~req_kill) | req_post;
      gnt_pending = '0;
      if (!HRESETn || !DMA_EN) begin
        m_st = 0; m_cnt = 0; DMA_BUSY = 1'b0; DMA_DONE = 1'b0;
      end else begin
        case (m_st)
          0: if (DMA_GO) begin DMA_BUSY = 1'b1; m_cnt = 0; m_st = 1; end
          1: begin
            m_cnt++;
            if (m_cnt >= run_len) begin DMA_BUSY = 1'b0; DMA_DONE = 1'b1; m_st = 2; end
          end
          2: if (!DMA_GO) begin
            m_cnt = 0;
            if (hold_len == 0) begin DMA_DONE = 1'b0; m_st = 0; end
            else m_st = 3;
          end
          3: begin
            m_cnt++;
            if (m_cnt >= hold_len) begin DMA_DONE = 1'b0; m_st = 0; end
          end
          default: m_st = 0;
        endcase
      end
      @(negedge HCLK);
      cyc++;
      if (DMA_GO) go_cnt++;
      if (req_rdy != '0) begin
        chk("req_rdy_onehot", $onehot(req_rdy), 1);
        grant_q.push_back(idx_of(req_rdy));
        grant_cyc_q.push_back(cyc);
        gnt_pending = gnt_pending | req_rdy;
      end
      if (cmp_vld != '0) begin
        chk("cmp_vld_onehot", $onehot(cmp_vld), 1);
        chk("rdy_cmp_same_chan", req_rdy & cmp_vld, 0);
        cmp_ch_q.push_back(idx_of(cmp_vld));
        cmp_err_q.push_back(int'(cmp_err));
        cmp_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(negedge HCLK); #1;
  endtask

  task automatic post(input logic [NCH-1:0] m);
    req_post = m;
    tick();
    req_post = '0;
  endtask

  task automatic set_desc(input int ch, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] b, input logic [4:0] bu);
    req_src[ch*32 +: 32]  = s;
    req_dst[ch*32 +: 32]  = d;
    req_bnum[ch*16 +: 16] = b;
    req_burst[ch*5 +: 5]  = bu;
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (grant_q.size() < n && k < budget) begin tick(); k++; end
    if (grant_q.size() < n) chk(name, grant_q.size(), n);
  endtask

  task automatic wait_cmps(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (cmp_ch_q.size() < n && k < budget) begin tick(); k++; end
    if (cmp_ch_q.size() < n) chk(name, cmp_ch_q.size(), n);
  endtask

  typedef struct {
    int          ch;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] bnum;
    logic [4:0]  burst;
    int          rl;
    bit          err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g0, c0, gc0, desc_bad, hold_cyc, k;
    tbl[0] = '{0, 32'h0000_1000, 32'h0000_2000, 16'd16, BURST_INC4,   20, 1'b0};
    tbl[1] = '{1, 32'h0000_3000, 32'h0000_4000, 16'd0,  BURST_INC4,    5, 1'b1};
    tbl[2] = '{2, 32'h0000_5004, 32'h0000_6008, 16'd64, BURST_INC8,    6, 1'b0};
    tbl[3] = '{3, 32'h0000_7000, 32'h0000_8000, 16'd32, 5'd0,          5, 1'b1};
    tbl[4] = '{1, 32'h0000_9000, 32'h0000_A000, 16'd1,  BURST_SINGLE,  2, 1'b0};

    total = 0; bad = 0;
    HRESETn = 1'b0; EN = 1'b0; req_post = '0; req_kill = '0;
    run_len = 20; hold_len = 0;
    req_src = '0; req_dst = '0; req_bnum = '0; req_burst = '0;
    repeat (3) tick();

    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_cmp_vld", cmp_vld, 0);
    chk("rst_cmp_err", cmp_err, 0);
    chk("rst_busy", sched_busy, 0);
    chk("rst_cur_chan", cur_chan, 0);
    chk("rst_dma_en", DMA_EN, 0);
    chk("rst_dma_go", DMA_GO, 0);
    chk("rst_desc", {DMA_SRC, DMA_DST[15:0], DMA_BNUM}, 0);
    chk("rst_burst", DMA_BURST, 0);

    // all four channels from reset, held until served
    for (int i = 0; i < NCH; i++)
      set_desc(i, 32'h100 * (i + 1), 32'h1000 + 32'h100 * i, 16'd4, BURST_SINGLE);
    run_len = 3;
    HRESETn = 1'b1; EN = 1'b1;
    g0 = grant_q.size(); c0 = cmp_ch_q.size();
    post(4'b1111);
    wait_grants(g0 + 4, 200, "rr_grant_timeout");
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order_%0d", i), gq(g0 + i), i);
    wait_cmps(c0 + 4, 100, "rr_cmp_timeout");
    for (int i = 0; i < 4; i++) chk($sformatf("rr_cmp_err_%0d", i), ceq(c0 + i), 0);
    repeat (2) tick();
    g0 = grant_q.size(); c0 = cmp_ch_q.size();
    post(4'b0101);
    wait_grants(g0 + 2, 100, "rr_wrap_timeout");
    chk("rr_wrap_first", gq(g0), 0);
    chk("rr_wrap_second", gq(g0 + 1), 2);
    wait_cmps(c0 + 2, 100, "rr_wrap_cmp_timeout");
    repeat (2) tick();

    // single-channel descriptor table
    for (int n = 0; n < 5; n++) begin
      set_desc(tbl[n].ch, tbl[n].src, tbl[n].dst, tbl[n].bnum, tbl[n].burst);
      run_len = tbl[n].rl;
      g0 = grant_q.size(); c0 = cmp_ch_q.size(); gc0 = go_cnt;
      post(NCH'(1) << tbl[n].ch);
      wait_grants(g0 + 1, 50, $sformatf("tbl%0d_grant_timeout", n));
      chk($sformatf("tbl%0d_grant_ch", n), gq(g0), tbl[n].ch);
      tick();
      chk($sformatf("tbl%0d_src", n), DMA_SRC, tbl[n].src);
      chk($sformatf("tbl%0d_dst", n), DMA_DST, tbl[n].dst);
      chk($sformatf("tbl%0d_bnum_burst", n), {DMA_BNUM, DMA_BURST}, {tbl[n].bnum, tbl[n].burst});
      chk($sformatf("tbl%0d_busy_chan", n), {sched_busy, cur_chan}, {1'b1, CHW'(tbl[n].ch)});
      wait_cmps(c0 + 1, 200, $sformatf("tbl%0d_cmp_timeout", n));
      chk($sformatf("tbl%0d_cmp_ch", n), cq(c0), tbl[n].ch);
      chk($sformatf("tbl%0d_cmp_err", n), ceq(c0), int'(tbl[n].err));
      chk($sformatf("tbl%0d_latency", n), ccq(c0) - gcq(g0), tbl[n].err ? 2 : tbl[n].rl + 4);
      chk($sformatf("tbl%0d_go_seen", n), go_cnt > gc0, !tbl[n].err);
      tick();
      chk($sformatf("tbl%0d_idle", n), {sched_busy, DMA_GO}, 0);
    end

    // EN dropped while ch3 is running
    run_len = 50;
    set_desc(3, 32'h0000_C000, 32'h0000_D000, 16'd128, BURST_INC16);
    set_desc(1, 32'h0000_E000, 32'h0000_F000, 16'd8, BURST_INC4);
    g0 = grant_q.size(); c0 = cmp_ch_q.size();
    post(4'b1000);
    wait_grants(g0 + 1, 50, "en_grant_timeout");
    chk("en_grant_ch3", gq(g0), 3);
    repeat (6) tick();
    chk("en_running", {sched_busy, DMA_GO, DMA_BUSY}, 3'b111);
    EN = 1'b0;
    chk("en_dma_en_latency", DMA_EN, 1);
    post(4'b0010);
    chk("en_abort_go_en", {DMA_GO, DMA_EN, sched_busy}, 0);
    chk("en_abort_cmp", {cmp_vld, cmp_err}, {4'b1000, 1'b1});
    wait_cmps(c0 + 1, 5, "en_cmp_timeout");
    chk("en_abort_cmp_q", {cq(c0), ceq(c0)}, {32'd3, 32'd1});
    repeat (8) tick();
    chk("en_no_grant_while_off", grant_q.size(), g0 + 1);
    run_len = 4;
    EN = 1'b1;
    wait_grants(g0 + 2, 20, "en_resume_timeout");
    chk("en_resume_ch1", gq(g0 + 1), 1);
    wait_cmps(c0 + 2, 50, "en_resume_cmp_timeout");
    chk("en_resume_cmp", {cq(c0 + 1), ceq(c0 + 1)}, {32'd1, 32'd0});
    repeat (2) tick();

    // master holds DONE for 10 cycles after GO drops
    run_len = 3; hold_len = 10;
    set_desc(0, 32'h0001_0000, 32'h0002_0000, 16'd48, BURST_INC8);
    set_desc(1, 32'h0003_0000, 32'h0004_0000, 16'd4, BURST_SINGLE);
    g0 = grant_q.size(); c0 = cmp_ch_q.size();
    post(4'b0001);
    wait_grants(g0 + 1, 50, "hold_grant_timeout");
    chk("hold_grant_ch0", gq(g0), 0);
    tick();
    post(4'b0010);
    desc_bad = 0; hold_cyc = 0; k = 0;
    while (cmp_ch_q.size() == c0 && k < 100) begin
      tick(); k++;
      if ({DMA_SRC, DMA_DST, DMA_BNUM, DMA_BURST} !== {32'h0001_0000, 32'h0002_0000, 16'd48, BURST_INC8})
        desc_bad++;
      if (DMA_DONE && !DMA_GO) hold_cyc++;
    end
    chk("hold_desc_stable", desc_bad, 0);
    chk("hold_done_cycles", hold_cyc, 10);
    chk("hold_cmp", {cq(c0), ceq(c0)}, {32'd0, 32'd0});
    chk("hold_latency", ccq(c0) - gcq(g0), 17);
    wait_grants(g0 + 2, 20, "hold_next_grant_timeout");
    chk("hold_next_grant_ch1", gq(g0 + 1), 1);
    chk("hold_no_early_grant", gcq(g0 + 1) >= ccq(c0), 1);
    wait_cmps(c0 + 2, 100, "hold_cmp2_timeout");
    hold_len = 0;
    repeat (2) tick();

    // reset in the middle of a transfer
    run_len = 40;
    set_desc(2, 32'h0005_0000, 32'h0006_0000, 16'd64, BURST_INC4);
    g0 = grant_q.size();
    post(4'b0100);
    wait_grants(g0 + 1, 50, "rst_grant_timeout");
    chk("rst_mid_grant_ch2", gq(g0), 2);
    repeat (5) tick();
    chk("rst_mid_running", {sched_busy, DMA_GO}, 2'b11);
    HRESETn = 1'b0;
    #1;
    chk("rst_async_ctrl", {sched_busy, DMA_GO, DMA_EN, cmp_err}, 0);
    chk("rst_async_vld", {req_rdy, cmp_vld}, 0);
    chk("rst_async_desc", {DMA_SRC, DMA_BNUM, DMA_BURST}, 0);
    c0 = cmp_ch_q.size();
    req_kill = '1;
    repeat (3) tick();
    chk("rst_no_cmp", cmp_ch_q.size(), c0);
    req_kill = '0;
    run_len = 3;
    set_desc(0, 32'h0007_0000, 32'h0008_0000, 16'd4, BURST_SINGLE);
    set_desc(1, 32'h0009_0000, 32'h000A_0000, 16'd4, BURST_SINGLE);
    set_desc(3, 32'h000B_0000, 32'h000C_0000, 16'd4, BURST_SINGLE);
    HRESETn = 1'b1;
    g0 = grant_q.size();
    post(4'b1011);
    wait_grants(g0 + 2, 100, "rst_after_grant_timeout");
    chk("rst_after_first_ch0", gq(g0), 0);
    chk("rst_after_second_ch1", gq(g0 + 1), 1);
    wait_grants(g0 + 3, 100, "rst_after_third_timeout");
    chk("rst_after_third_ch3", gq(g0 + 2), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
